// File: rtl/cfg_regbank.sv
// Double-buffered configuration register bank: host writes land in a shadow
// bank and reach config_bits atomically on commit; masked indices are read-only status.
module cfg_regbank #(
   parameter int                         NUMREGS     = 6,
   parameter int                         DATA_W      = 8,
   parameter int                         ADDR_W      = 8,
   parameter logic [NUMREGS*DATA_W-1:0]  RESET_VALS  = '0,
   parameter logic [NUMREGS-1:0]         STATUS_MASK = '0
) (
   input  logic              clk,
   input  logic              reset,
   output logic [DATA_W-1:0] config_bits [0:NUMREGS-1],
   input  logic [DATA_W-1:0] status_in   [0:NUMREGS-1],
   input  logic              write,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data,
   input  logic              read,
   input  logic [ADDR_W-1:0] read_addr,
   output logic [DATA_W-1:0] read_data,
   output logic              read_valid,
   input  logic              commit,
   output logic              dirty,
   output logic              err,
   input  logic              err_clr
);

   logic [NUMREGS-1:0] wr_hit;
   logic [NUMREGS-1:0] rd_hit;
   logic [NUMREGS-1:0] wr_sel;
   logic               wr_legal;
   logic               wr_bad;
   logic               rd_oob;
   logic [DATA_W-1:0]  rd_src [0:NUMREGS-1];
   logic [DATA_W-1:0]  rd_mux;

   // Full address compare per index, so upper address bits never alias.
   always_comb begin
      wr_hit = '0;
      rd_hit = '0;
      for (int i = 0; i < NUMREGS; i++) begin
         wr_hit[i] = write && (write_addr == ADDR_W'(i));
         rd_hit[i] = read  && (read_addr  == ADDR_W'(i));
      end
   end

   assign wr_sel   = wr_hit & ~STATUS_MASK;
   assign wr_legal = |wr_sel;
   assign wr_bad   = write && !wr_legal;
   assign rd_oob   = read && !(|rd_hit);

   for (genvar g = 0; g < NUMREGS; g++) begin : g_reg
      if (STATUS_MASK[g]) begin : g_status
         assign config_bits[g] = '0;
         assign rd_src[g]      = status_in[g];
      end else begin : g_config
         logic [DATA_W-1:0] shadow;
         logic [DATA_W-1:0] live;
         logic              unused_status;

         // A write coinciding with commit is forwarded straight into live.
         always_ff @(posedge clk) begin
            if (reset) begin
               shadow <= RESET_VALS[g*DATA_W +: DATA_W];
               live   <= RESET_VALS[g*DATA_W +: DATA_W];
            end else begin
               if (wr_sel[g])
                  shadow <= write_data;
               if (commit)
                  live <= wr_sel[g] ? write_data : shadow;
            end
         end

         assign config_bits[g] = live;
         assign rd_src[g]      = shadow;
         assign unused_status  = ^status_in[g];
      end
   end

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUMREGS; i++) begin
         if (rd_hit[i])
            rd_mux = rd_src[i];
      end
   end

   // Readback stage: rd_src is the pre-write shadow, giving read-before-write.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_data  <= '0;
         read_valid <= 1'b0;
      end else begin
         read_valid <= read;
         if (read)
            read_data <= rd_mux;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dirty <= 1'b0;
         err   <= 1'b0;
      end else begin
         if (commit)
            dirty <= 1'b0;
         else if (wr_legal)
            dirty <= 1'b1;

         if (wr_bad || rd_oob)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
      end
   end

endmodule
